crypto_stream_seq: RTL and testbench

Stream-to-block sequencer that sits directly in front of and behind `crypto_engine`. It packs a 32-bit AXI-Stream packet into 128-bit blocks and issues one clean `start` pulse per block. It waits for the engine's `done`, then unpacks each result block back onto a 32-bit AXI-Stream. It also polices packet length and alignment before the engine sees anything, and optionally watchdogs the engine.

---
 rtl/crypto_pkg.sv | 28 ++
 rtl/crypto_stream_seq_if.sv | 16 +
 rtl/crypto_seq_watchdog.sv | 32 +++
 rtl/crypto_stream_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_crypto_stream_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_pkg.sv
// crypto_pkg: shared types and constants for the crypto stream sequencer.
//   seq_state_e   - sequencer FSM states
//   BLK_W/WORD_W  - engine block width and stream word width
//   WORDS_PER_BLK - stream words per engine block
//   ALIGN_MASK    - low length bits that must be clear for a whole-block packet
package crypto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_START,
        ST_WAIT,
        ST_UNPACK,
        ST_DROP
    } seq_state_e;

    localparam int BLK_W         = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = 4;

    localparam logic [31:0] ALIGN_MASK = 32'h0000_000F;

    // A packet the engine can take must be a non-zero whole number of blocks.
    function automatic logic len_bad(input logic [31:0] len);
        return (len == '0) || ((len & ALIGN_MASK) != '0);
    endfunction

endpackage

// File: rtl/crypto_stream_seq_if.sv
// crypto_stream_seq_if: 32-bit AXI-Stream bundle used on both sides of the
// sequencer.
//   tdata/tvalid/tlast - driven by the master
//   tready             - driven by the slave
interface crypto_stream_seq_if;
    import crypto_pkg::*;

    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/crypto_seq_watchdog.sv
// crypto_seq_watchdog: engine watchdog for the stream sequencer.
//   clk, rst_n - clock, async active-low reset
//   clr        - reload the down-counter (issued as the sequencer enters WAIT)
//   en         - count while waiting on the engine
//   expired    - high for the cycle in which TIMEOUT_CYCLES have elapsed
module crypto_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [31:0] LOAD = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 32'd1;
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/crypto_stream_seq.sv
// crypto_stream_seq: packs a 32-bit AXI-Stream packet into 128-bit blocks for
// crypto_engine, issues one start pulse per block, and unpacks each result
// onto a 32-bit AXI-Stream. Polices packet length/alignment up front.
//   clk, rst_n            - clock, async active-low reset
//   s_axis (slave)        - plaintext stream in
//   m_axis (master)       - ciphertext stream out
//   i_total_len           - packet length in bytes, sampled on first beat
//   eng_*                 - engine start/length/data and busy/done/result
//   o_err_align/len/timeout - single-cycle error pulses
//   o_blk_cnt             - blocks completed since reset
// Build option: CRYPTO_SEQ_TIMEOUT_EN adds the engine watchdog.
//
// state  | meaning
// IDLE   | ready for first beat of a packet
// FILL   | collecting words 1..3 (or 0..3 on later blocks)
// START  | block full, waiting for engine idle, then pulse start
// WAIT   | engine running, eng_din held
// UNPACK | emitting result words MSW first
// DROP   | discarding beats up to tlast
module crypto_stream_seq
    import crypto_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    crypto_stream_seq_if.slave  s_axis,
    crypto_stream_seq_if.master m_axis,
    input  logic [31:0]         i_total_len,
    output logic                eng_start,
    output logic [31:0]         eng_total_len,
    output logic [BLK_W-1:0]    eng_din,
    input  logic                eng_busy,
    input  logic                eng_done,
    input  logic [BLK_W-1:0]    eng_dout,
    output logic                o_err_align,
    output logic                o_err_len,
    output logic                o_err_timeout,
    output logic [31:0]         o_blk_cnt
);

    localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLK - 1);

    seq_state_e       state, state_d;
    logic [1:0]       widx, widx_d, oidx, oidx_d;
    logic [27:0]      blk_rem, blk_rem_d;
    logic             tlast_seen, tlast_seen_d;
    logic             miss_last, miss_last_d;
    logic [BLK_W-1:0] din_q, din_d, dout_buf, dout_buf_d;
    logic [31:0]      len_q, len_d, blk_cnt, blk_cnt_d;
    logic             start_d, err_align_d, err_len_d, err_to_d;
    logic             s_beat, m_beat, final_word;
    logic             wd_clr, wd_en, wd_expired;

    assign s_axis.tready = (state == ST_IDLE) || (state == ST_FILL) || (state == ST_DROP);
    assign s_beat        = s_axis.tvalid && s_axis.tready;

    // Result buffer shifts left per beat, so the current word is always on top.
    assign m_axis.tvalid = (state == ST_UNPACK);
    assign m_axis.tdata  = dout_buf[BLK_W-1 -: WORD_W];
    assign m_axis.tlast  = (state == ST_UNPACK) && (oidx == LAST_IDX) && (blk_rem == 28'd1);
    assign m_beat        = m_axis.tvalid && m_axis.tready;

    assign final_word = (widx == LAST_IDX) && (blk_rem == 28'd1);

    always_comb begin
        state_d      = state;
        widx_d       = widx;
        oidx_d       = oidx;
        blk_rem_d    = blk_rem;
        tlast_seen_d = tlast_seen;
        miss_last_d  = miss_last;
        din_d        = din_q;
        dout_buf_d   = dout_buf;
        len_d        = len_q;
        blk_cnt_d    = blk_cnt;
        start_d      = 1'b0;
        err_align_d  = 1'b0;
        err_len_d    = 1'b0;
        err_to_d     = 1'b0;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_beat) begin
                    len_d        = i_total_len;
                    blk_rem_d    = i_total_len[31:4];
                    din_d        = {din_q[BLK_W-WORD_W-1:0], s_axis.tdata};
                    tlast_seen_d = s_axis.tlast;
                    miss_last_d  = 1'b0;
                    if (len_bad(i_total_len)) begin
                        err_align_d = 1'b1;
                        state_d     = s_axis.tlast ? ST_IDLE : ST_DROP;
                    end else if (s_axis.tlast) begin
                        // word 0 can never be the final word of a legal packet
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        widx_d  = 2'd1;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (s_beat) begin
                    din_d        = {din_q[BLK_W-WORD_W-1:0], s_axis.tdata};
                    tlast_seen_d = s_axis.tlast;
                    if (s_axis.tlast && !final_word) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        widx_d = widx + 2'd1;
                        if (widx == LAST_IDX) begin
                            miss_last_d = final_word && !s_axis.tlast;
                            state_d     = ST_START;
                        end
                    end
                end
            end
            ST_START: begin
                if (!eng_busy) begin
                    start_d = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                if (eng_done) begin
                    dout_buf_d = eng_dout;
                    blk_cnt_d  = blk_cnt + 32'd1;
                    oidx_d     = 2'd0;
                    state_d    = ST_UNPACK;
                end else if (wd_expired) begin
                    err_to_d = 1'b1;
                    state_d  = tlast_seen ? ST_IDLE : ST_DROP;
                end
            end
            ST_UNPACK: begin
                if (m_beat) begin
                    dout_buf_d = {dout_buf[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                    oidx_d     = oidx + 2'd1;
                    if (oidx == LAST_IDX) begin
                        blk_rem_d = blk_rem - 28'd1;
                        if (blk_rem == 28'd1) begin
                            if (miss_last) begin
                                err_len_d = 1'b1;
                                state_d   = ST_DROP;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            widx_d  = 2'd0;
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_beat && s_axis.tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            widx          <= '0;
            oidx          <= '0;
            blk_rem       <= '0;
            tlast_seen    <= 1'b0;
            miss_last     <= 1'b0;
            din_q         <= '0;
            dout_buf      <= '0;
            len_q         <= '0;
            blk_cnt       <= '0;
            eng_start     <= 1'b0;
            o_err_align   <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            state         <= state_d;
            widx          <= widx_d;
            oidx          <= oidx_d;
            blk_rem       <= blk_rem_d;
            tlast_seen    <= tlast_seen_d;
            miss_last     <= miss_last_d;
            din_q         <= din_d;
            dout_buf      <= dout_buf_d;
            len_q         <= len_d;
            blk_cnt       <= blk_cnt_d;
            eng_start     <= start_d;
            o_err_align   <= err_align_d;
            o_err_len     <= err_len_d;
            o_err_timeout <= err_to_d;
        end
    end

    assign eng_din       = din_q;
    assign eng_total_len = len_q;
    assign o_blk_cnt     = blk_cnt;

`ifdef CRYPTO_SEQ_TIMEOUT_EN
    crypto_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );
`else
    logic unused_wdog;
    assign wd_expired  = 1'b0;
    assign unused_wdog = ^{wd_clr, wd_en, TIMEOUT_CYCLES};
`endif

endmodule

// File: tb/tb_crypto_stream_seq.sv
module tb_crypto_stream_seq;
    import crypto_pkg::*;

    localparam int          ENG_LAT = 10;
    localparam int unsigned TO_CYC  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crypto_stream_seq_if s_if ();
    crypto_stream_seq_if m_if ();

    logic [31:0]  i_total_len, eng_total_len, o_blk_cnt;
    logic         eng_start, eng_busy, eng_done;
    logic         o_err_align, o_err_len, o_err_timeout;
    logic [127:0] eng_din, eng_dout;

    crypto_stream_seq #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .i_total_len  (i_total_len),
        .eng_start    (eng_start),
        .eng_total_len(eng_total_len),
        .eng_din      (eng_din),
        .eng_busy     (eng_busy),
        .eng_done     (eng_done),
        .eng_dout     (eng_dout),
        .o_err_align  (o_err_align),
        .o_err_len    (o_err_len),
        .o_err_timeout(o_err_timeout),
        .o_blk_cnt    (o_blk_cnt)
    );

    int n_pass = 0, n_total = 0, cyc = 0;
    int n_start = 0, n_align = 0, n_len = 0, n_to = 0, n_mvalid = 0;
    int t_start = 0, t_to = 0;
    logic [32:0]  exp_q[$];
    logic [127:0] blk_q[$];
    logic         eng_hang = 1'b0;
    int           lat;
    logic [127:0] eng_blk;
    logic         hold_v = 1'b0;
    logic [32:0]  hold_w;

    function automatic logic [127:0] eng_fn(input logic [127:0] b);
        return {b[95:0], b[127:96]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Engine model: fixed latency, ignores start while hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b0;
            eng_dout <= '0;
            eng_blk  <= '0;
            lat      <= 0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start && !eng_hang) begin
                eng_busy <= 1'b1;
                eng_blk  <= eng_din;
                lat      <= ENG_LAT - 1;
            end else if (eng_busy) begin
                if (lat == 0) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                    eng_dout <= eng_fn(eng_blk);
                end else begin
                    lat <= lat - 1;
                end
            end
        end
    end

    always @(posedge clk) cyc++;

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (eng_start) begin
                n_start++;
                t_start = cyc;
                chk("start_has_block", blk_q.size() > 0, 1'b1);
                if (blk_q.size() > 0) chk("eng_din", eng_din, blk_q.pop_front());
            end
            if (o_err_align) n_align++;
            if (o_err_len) n_len++;
            if (o_err_timeout) begin n_to++; t_to = cyc; end
            if (m_if.tvalid) begin
                n_mvalid++;
                if (hold_v) chk("m_hold_stable", {m_if.tlast, m_if.tdata}, hold_w);
                if (m_if.tready) begin
                    hold_v = 1'b0;
                    chk("m_word_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) chk("m_word", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
                end else begin
                    hold_v = 1'b1;
                    hold_w = {m_if.tlast, m_if.tdata};
                end
            end else begin
                if (hold_v) chk("m_valid_dropped", m_if.tvalid, 1'b1);
                hold_v = 1'b0;
            end
        end
    end

    task automatic push_block(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input bit final_blk, input bit expect_out);
        logic [127:0] b, r;
        b = {w0, w1, w2, w3};
        blk_q.push_back(b);
        if (expect_out) begin
            r = eng_fn(b);
            for (int i = 0; i < 4; i++)
                exp_q.push_back({(final_blk && i == 3), r[127-32*i -: 32]});
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, inout int acc);
        int n = 0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (s_if.tready) begin
            acc++;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] first, input int n, input int last_pos, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++)
            send_word(first + 32'(i), (i + 1) == last_pos, acc);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || blk_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size() + blk_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int acc, s0, a0, l0, t0, v0, n;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        i_total_len = '0;

        // reset state
        #12;
        chk("rst_s_tready", s_if.tready, 1'b1);
        chk("rst_outputs", {eng_start, m_if.tvalid, m_if.tlast, o_err_align, o_err_len, o_err_timeout}, '0);
        chk("rst_eng_din", eng_din, '0);
        chk("rst_len_cnt_data", {eng_total_len, o_blk_cnt, m_if.tdata}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // two-block packet
        s0 = n_start;
        i_total_len = 32;
        push_block(1, 2, 3, 4, 0, 1);
        push_block(5, 6, 7, 8, 1, 1);
        send_pkt(32'd1, 8, 8, acc);
        chk("t1_accepted", acc, 8);
        chk("t1_total_len", eng_total_len, 32);
        wait_drain("t1_drain");
        chk("t1_starts", n_start - s0, 2);
        chk("t1_blk_cnt", o_blk_cnt, 2);

        // misaligned length
        s0 = n_start; a0 = n_align; v0 = n_mvalid;
        i_total_len = 20;
        send_pkt(32'h10, 5, 5, acc);
        repeat (20) @(posedge clk); #1;
        chk("t2_accepted", acc, 5);
        chk("t2_align_pulses", n_align - a0, 1);
        chk("t2_no_start", n_start - s0, 0);
        chk("t2_no_mvalid", n_mvalid - v0, 0);
        chk("t2_idle_ready", s_if.tready, 1'b1);

        // early tlast in the second block
        s0 = n_start; l0 = n_len;
        i_total_len = 32;
        push_block(32'h100, 32'h101, 32'h102, 32'h103, 0, 1);
        send_pkt(32'h100, 6, 6, acc);
        wait_drain("t3_drain");
        chk("t3_accepted", acc, 6);
        chk("t3_len_pulses", n_len - l0, 1);
        chk("t3_starts", n_start - s0, 1);
        chk("t3_blk_cnt", o_blk_cnt, 3);
        chk("t3_idle_ready", s_if.tready, 1'b1);

        // output backpressure
        i_total_len = 16;
        m_if.tready = 1'b0;
        push_block(32'h300, 32'h301, 32'h302, 32'h303, 1, 1);
        send_pkt(32'h300, 4, 4, acc);
        chk("t4_accepted", acc, 4);
        n = 0;
        while (!m_if.tvalid && n < 100) begin @(negedge clk); n++; end
        chk("t4_mvalid_seen", m_if.tvalid, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("t4_stall_tdata", m_if.tdata, exp_q[0][31:0]);
            chk("t4_stall_s_tready", s_if.tready, 1'b0);
        end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_blk_cnt", o_blk_cnt, 4);

        // final word arrives without tlast
        l0 = n_len;
        i_total_len = 16;
        push_block(32'h200, 32'h201, 32'h202, 32'h203, 1, 1);
        send_pkt(32'h200, 6, 6, acc);
        wait_drain("t5_drain");
        chk("t5_accepted", acc, 6);
        chk("t5_len_pulses", n_len - l0, 1);
        chk("t5_blk_cnt", o_blk_cnt, 5);

`ifdef CRYPTO_SEQ_TIMEOUT_EN
        // engine never completes
        t0 = n_to; v0 = n_mvalid;
        eng_hang = 1'b1;
        i_total_len = 32;
        push_block(32'h400, 32'h401, 32'h402, 32'h403, 0, 0);
        send_pkt(32'h400, 8, 8, acc);
        repeat (10) @(posedge clk); #1;
        chk("to_accepted", acc, 8);
        chk("to_pulses", n_to - t0, 1);
        chk("to_delay", t_to - t_start, TO_CYC);
        chk("to_blk_cnt", o_blk_cnt, 5);
        chk("to_no_mvalid", n_mvalid - v0, 0);
        eng_hang = 1'b0;
`else
        t0 = n_to;
        chk("no_timeout_pulses", n_to - t0, 0);
`endif

        // reset while waiting on the engine
        s0 = n_start;
        i_total_len = 16;
        push_block(32'h500, 32'h501, 32'h502, 32'h503, 1, 0);
        send_pkt(32'h500, 4, 4, acc);
        n = 0;
        while (n_start == s0 && n < 50) begin @(posedge clk); n++; end
        chk("rw_started", n_start - s0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rw_eng_din", eng_din, '0);
        chk("rw_len_cnt_data", {eng_total_len, o_blk_cnt, m_if.tdata}, '0);
        chk("rw_flags", {eng_start, m_if.tvalid, o_err_align, o_err_len, o_err_timeout, s_if.tready}, 6'b000001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_block(32'h600, 32'h601, 32'h602, 32'h603, 1, 1);
        send_pkt(32'h600, 4, 4, acc);
        wait_drain("rw_drain");
        chk("rw_accepted", acc, 4);
        chk("rw_blk_cnt", o_blk_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
